pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Fetch-stage PC generator for the pipelined MIPS core.
- Holds the architectural fetch PC (pc_f) and selects the next PC from sequential, j/jal, branch, jr, exception-entry and eret sources.
- Buffers a D-stage redirect that arrives while fetch is stalled, so it is never lost.
- Parametrised successor of the combinational next-PC selector: adds a register, stall handling, a pending-redirect buffer, exception/eret priority, and configurable vectors and offset width.

Parameters:
- RESET_PC, 32'h0000_3000, pc_f value after reset.
- EXC_VECTOR, 32'h0000_4180, exception-entry target.
- OFF_W, 16, width of the sign-extended branch offset field used (bits above OFF_W ignored).
- TEXT_LO, 32'h0000_3000, lowest legal fetch address (optional feature only).
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall_f  in  1  hold pc_f this cycle.
- ctrl_valid  in  1  D-stage control info is valid (operands resolved).
- pc_d  in  32  PC of the instruction in D.
- instr26  in  26  j/jal index field.
- offset  in  32  sign-extended branch immediate.
- reg_to_jump  in  32  forwarded rs value for jr.
- jump  in  1  j/jal in D.
- branch  in  1  taken branch in D.
- jr  in  1  jr/jalr in D.
- exc_req  in  1  exception taken (from M).
- eret  in  1  eret committing.
- epc  in  32  eret return address.
- pc_f  out  32  current fetch PC.
- next_pc  out  32  value pc_f takes at the next edge (combinational).
- pending_valid  out  1  a buffered redirect is held.
- adel_f  out  1  fetch address error (optional feature).

Behaviour:
- Reset is synchronous, active-high: pc_f<=RESET_PC, pending_valid<=0, pending_target<=0, adel_f=0. Reset overrides every other input in the same cycle.
- Control target (D), priority jump > branch > jr:
  - jump: {pc_d[31:28], instr26, 2'b00}.
  - branch: pc_d + 4 + (sext(offset[OFF_W-1:0]) << 2), modulo 2^32, wrap-around allowed.
  - jr: reg_to_jump.
- ctl_hit = ctrl_valid & (jump | branch | jr). When ctrl_valid=0 the D inputs are ignored.
- Next-PC priority, highest first:
  1. exc_req -> EXC_VECTOR. Ignores stall_f and clears pending.
  2. eret -> epc. Ignores stall_f and clears pending.
  3. stall_f=1 -> hold pc_f. If ctl_hit, pending_target <= control target and pending_valid <= 1; a later ctl_hit during the same stall overwrites it.
  4. ctl_hit -> control target. Clears pending.
  5. pending_valid -> pending_target. Clears pending.
  6. otherwise pc_f + 4, wrapping at 32'hffff_fffc -> 0.
- exc_req and eret together: exc_req wins.
- next_pc equals the chosen value every cycle. It equals pc_f while stalled.
- Latency: a redirect visible in cycle n appears on pc_f in cycle n+1, or in the first unstalled cycle plus one when it was buffered.
- Reset asserted while a redirect is pending: pending is discarded.

Optional Feature:
- Macro NPC_ALIGN_CHK_EN.
- Defined: adel_f = (pc_f[1:0] != 0) | (pc_f < TEXT_LO) | (pc_f > TEXT_HI), combinational from the registered pc_f. pc_f advances normally; the exception unit consumes adel_f.
- Undefined: adel_f tied to 0, TEXT_LO/TEXT_HI unused.

Decomposition:
- Shared package pc_pkg holds:
  - RESET_PC and EXC_VECTOR defaults.
  - Constant PC_STEP=4.
  - A 3-bit enum for the selected source: SEQ, CTL, PEND, EXC, ERET, HOLD.
- One natural sub-module, npc_target_sel: the combinational jump/branch/jr target mux, parametrised by OFF_W.
- pc_gen instantiates npc_target_sel and holds the registers and priority logic.

Test Plan:
- Reset: assert reset 2 cycles, then deassert with no inputs -> pc_f 0x3000, 0x3004, 0x3008 on consecutive cycles; pending_valid=0.
- Branch: pc_d=0x3010, offset=32'hffff_fffe, branch=1, ctrl_valid=1 -> next cycle pc_f=0x300c. Jump with instr26=26'h0000c10 -> pc_f=0x3040.
- Buffered redirect: stall_f=1 for 3 cycles with jr=1, reg_to_jump=0x3200 in cycle 1 only -> pc_f held and pending_valid=1. First unstalled cycle -> pc_f=0x3200, pending_valid=0.
- Exception during stall: stall_f=1 with pending set, then exc_req=1 -> pc_f=0x4180, pending cleared. eret=1, epc=0x3104 -> pc_f=0x3104.
- Simultaneous sources: exc_req=1, eret=1, jump=1 -> pc_f=0x4180. jump=1 and branch=1 -> jump target chosen. ctrl_valid=0 with jump=1 -> pc_f+4.
- Wrap/optional: force pc_f=0xffff_fffc -> next 0x0. With NPC_ALIGN_CHK_EN, jr to 0x3002 -> adel_f=1 the following cycle; jr to 0x2ffc -> adel_f=1.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared PC defaults, step constant and next-PC source encoding
package pc_pkg;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] PC_STEP        = 32'd4;
    typedef enum logic [2:0] {SEQ, CTL, PEND, EXC, ERET, HOLD} npc_sel_e;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-PC generator bus; slave is pc_gen, master drives D/M/W-stage inputs
interface pc_gen_if;
    logic        stall_f;
    logic        ctrl_valid;
    logic [31:0] pc_d;
    logic [25:0] instr26;
    logic [31:0] offset;
    logic [31:0] reg_to_jump;
    logic        jump;
    logic        branch;
    logic        jr;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic [31:0] next_pc;
    logic        pending_valid;
    logic        adel_f;
    modport slave (
        input  stall_f, ctrl_valid, pc_d, instr26, offset, reg_to_jump,
               jump, branch, jr, exc_req, eret, epc,
        output pc_f, next_pc, pending_valid, adel_f
    );
    modport master (
        output stall_f, ctrl_valid, pc_d, instr26, offset, reg_to_jump,
               jump, branch, jr, exc_req, eret, epc,
        input  pc_f, next_pc, pending_valid, adel_f
    );
endinterface

// File: rtl/pc_gen_npc_target_sel.sv
// npc_target_sel: D-stage control target mux, priority jump > branch > jr
import pc_pkg::*;
module npc_target_sel #(
    parameter int OFF_W = 16
) (
    input  logic [31:0] pc_d,
    input  logic [25:0] instr26,
    input  logic [31:0] offset,
    input  logic [31:0] reg_to_jump,
    input  logic        jump,
    input  logic        branch,
    output logic [31:0] target
);
    logic [31:0] off_ext;
    logic [31:0] br_target;
    logic        unused_off;
    assign unused_off = ^offset;
    // Offset bits above OFF_W are ignored; the add wraps modulo 2^32
    always_comb begin
        off_ext   = 32'($signed(offset[OFF_W-1:0]));
        br_target = pc_d + PC_STEP + (off_ext << 2);
        target    = jump ? {pc_d[31:28], instr26, 2'b00} : branch ? br_target : reg_to_jump;
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with stall-safe redirect buffer; NPC_ALIGN_CHK_EN enables adel_f
import pc_pkg::*;
module pc_gen #(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          OFF_W      = 16,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.slave  bus
);
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic        pending_valid_q, pending_valid_d;
    logic [31:0] ctl_target;
    logic        ctl_hit;
    npc_sel_e    sel;

    npc_target_sel #(.OFF_W(OFF_W)) u_tsel (
        .pc_d        (bus.pc_d),
        .instr26     (bus.instr26),
        .offset      (bus.offset),
        .reg_to_jump (bus.reg_to_jump),
        .jump        (bus.jump),
        .branch      (bus.branch),
        .target      (ctl_target)
    );

    assign ctl_hit = bus.ctrl_valid & (bus.jump | bus.branch | bus.jr);

    // Source priority: exception, eret, stall hold, D redirect, buffered redirect, sequential
    always_comb begin
        sel = bus.exc_req ? EXC : bus.eret ? ERET : bus.stall_f ? HOLD :
              ctl_hit ? CTL : pending_valid_q ? PEND : SEQ;
        case (sel)
            EXC:     pc_f_d = EXC_VECTOR;
            ERET:    pc_f_d = bus.epc;
            HOLD:    pc_f_d = pc_f_q;
            CTL:     pc_f_d = ctl_target;
            PEND:    pc_f_d = pending_target_q;
            default: pc_f_d = pc_f_q + PC_STEP;
        endcase
        pending_valid_d  = (sel == HOLD) & (pending_valid_q | ctl_hit);
        pending_target_d = (sel == HOLD && ctl_hit) ? ctl_target : pending_target_q;
    end

    // PC and redirect buffer registers; reset discards any pending redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q           <= RESET_PC;
            pending_valid_q  <= 1'b0;
            pending_target_q <= 32'h0;
        end else begin
            pc_f_q           <= pc_f_d;
            pending_valid_q  <= pending_valid_d;
            pending_target_q <= pending_target_d;
        end
    end

    assign bus.pc_f          = pc_f_q;
    assign bus.next_pc       = pc_f_d;
    assign bus.pending_valid = pending_valid_q;
`ifdef NPC_ALIGN_CHK_EN
    assign bus.adel_f = (pc_f_q[1:0] != 2'b00) | (pc_f_q < TEXT_LO) | (pc_f_q > TEXT_HI);
`else
    logic unused_text;
    assign unused_text = ^{TEXT_LO, TEXT_HI};
    assign bus.adel_f  = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen
module tb_pc_gen;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
`ifdef NPC_ALIGN_CHK_EN
    localparam logic ADEL_ON = 1'b1;
`else
    localparam logic ADEL_ON = 1'b0;
`endif

    pc_gen_if bus ();
    pc_gen dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_f = 0; bus.ctrl_valid = 0; bus.jump = 0; bus.branch = 0; bus.jr = 0;
        bus.exc_req = 0; bus.eret = 0;
    endtask

    task automatic do_jr(input logic [31:0] t);
        bus.ctrl_valid = 1; bus.jr = 1; bus.reg_to_jump = t;
    endtask

    initial begin
        idle();
        bus.pc_d = 32'h0; bus.instr26 = 26'h0; bus.offset = 32'h0;
        bus.reg_to_jump = 32'h0; bus.epc = 32'h0;
        reset = 1;
        step(); step();
        chk("reset_pc", bus.pc_f, 32'h3000);
        chk("reset_pend", 32'(bus.pending_valid), 32'h0);
        reset = 0;
        step(); chk("seq1", bus.pc_f, 32'h3004);
        step(); chk("seq2", bus.pc_f, 32'h3008);
        chk("seq_pend", 32'(bus.pending_valid), 32'h0);
        // backward branch
        bus.pc_d = 32'h3010; bus.offset = 32'hffff_fffe; bus.branch = 1; bus.ctrl_valid = 1;
        #1 chk("br_npc", bus.next_pc, 32'h300c);
        step(); chk("br_pc", bus.pc_f, 32'h300c);
        // jump
        idle(); bus.instr26 = 26'h0000c10; bus.jump = 1; bus.ctrl_valid = 1;
        step(); chk("jmp_pc", bus.pc_f, 32'h3040);
        // redirect arriving during a 3-cycle stall
        idle(); bus.stall_f = 1; do_jr(32'h3200);
        #1 chk("stall_npc", bus.next_pc, 32'h3040);
        step(); chk("stall_pc1", bus.pc_f, 32'h3040);
        chk("stall_pend1", 32'(bus.pending_valid), 32'h1);
        idle(); bus.stall_f = 1;
        step(); chk("stall_pc2", bus.pc_f, 32'h3040);
        step(); chk("stall_pc3", bus.pc_f, 32'h3040);
        chk("stall_pend3", 32'(bus.pending_valid), 32'h1);
        bus.stall_f = 0;
        #1 chk("pend_npc", bus.next_pc, 32'h3200);
        step(); chk("pend_pc", bus.pc_f, 32'h3200);
        chk("pend_clr", 32'(bus.pending_valid), 32'h0);
        step(); chk("pend_seq", bus.pc_f, 32'h3204);
        // later redirect in the same stall overwrites the buffered one
        bus.stall_f = 1; do_jr(32'h3300);
        step(); do_jr(32'h3400);
        step(); idle();
        step(); chk("ovw_pc", bus.pc_f, 32'h3400);
        // exception during stall with pending set
        bus.stall_f = 1; do_jr(32'h3500);
        step(); chk("exc_pend_set", 32'(bus.pending_valid), 32'h1);
        idle(); bus.stall_f = 1; bus.exc_req = 1;
        #1 chk("exc_npc", bus.next_pc, 32'h4180);
        step(); chk("exc_pc", bus.pc_f, 32'h4180);
        chk("exc_pend_clr", 32'(bus.pending_valid), 32'h0);
        idle();
        step(); chk("exc_seq", bus.pc_f, 32'h4184);
        bus.eret = 1; bus.epc = 32'h3104; bus.stall_f = 1;
        step(); chk("eret_pc", bus.pc_f, 32'h3104);
        // simultaneous sources
        idle(); bus.exc_req = 1; bus.eret = 1; bus.jump = 1; bus.ctrl_valid = 1;
        step(); chk("exc_eret_pc", bus.pc_f, 32'h4180);
        idle(); bus.pc_d = 32'h3010; bus.offset = 32'hffff_fffe;
        bus.jump = 1; bus.branch = 1; bus.ctrl_valid = 1;
        step(); chk("jmp_over_br", bus.pc_f, 32'h3040);
        bus.ctrl_valid = 0;
        step(); chk("ctrl_invalid", bus.pc_f, 32'h3044);
        idle(); bus.eret = 1; bus.epc = 32'h3104; bus.jump = 1; bus.ctrl_valid = 1;
        step(); chk("eret_over_jmp", bus.pc_f, 32'h3104);
        // branch over jr, upper offset bits ignored, wrap-around branch
        idle(); bus.pc_d = 32'h3010; bus.offset = 32'h0001_0001; bus.branch = 1; bus.jr = 1;
        bus.reg_to_jump = 32'h3600; bus.ctrl_valid = 1;
        step(); chk("br_off_hi", bus.pc_f, 32'h3018);
        idle(); bus.pc_d = 32'hffff_fff0; bus.offset = 32'h0000_0004; bus.branch = 1; bus.ctrl_valid = 1;
        step(); chk("br_wrap", bus.pc_f, 32'h0000_0004);
        // sequential wrap
        idle(); do_jr(32'hffff_fffc);
        step(); chk("wrap_pre", bus.pc_f, 32'hffff_fffc);
        idle();
        #1 chk("wrap_npc", bus.next_pc, 32'h0);
        step(); chk("wrap_pc", bus.pc_f, 32'h0);
        chk("adel_low", 32'(bus.adel_f), 32'(ADEL_ON));
        // fetch address checks
        do_jr(32'h3002);
        step(); chk("adel_mis", 32'(bus.adel_f), 32'(ADEL_ON));
        do_jr(32'h2ffc);
        step(); chk("adel_below", 32'(bus.adel_f), 32'(ADEL_ON));
        do_jr(32'h6ffc);
        step(); chk("adel_hi_ok", 32'(bus.adel_f), 32'h0);
        do_jr(32'h7000);
        step(); chk("adel_above", 32'(bus.adel_f), 32'(ADEL_ON));
        // reset discards a pending redirect
        idle(); bus.stall_f = 1; do_jr(32'h3600);
        step(); chk("rst_pend_set", 32'(bus.pending_valid), 32'h1);
        idle(); reset = 1;
        step(); chk("rst_pc", bus.pc_f, 32'h3000);
        chk("rst_pend_clr", 32'(bus.pending_valid), 32'h0);
        reset = 0;
        step(); chk("rst_seq", bus.pc_f, 32'h3004);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
